// File: rtl/touch_key_cond.sv
// Touch-key conditioning: sync + debounce of the raw sensor, then short/double/long press classification.
// Optional auto-repeat while long-held is enabled by defining TOUCH_REPEAT_EN.
module touch_key_cond #(
    parameter int unsigned DEB_CYC  = 1000000,
    parameter int unsigned LONG_CYC = 50000000,
    parameter int unsigned DBL_CYC  = 15000000,
    parameter int unsigned REP_CYC  = 10000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic touch_raw,
    output logic key_level,
    output logic key_rise,
    output logic short_press,
    output logic double_press,
    output logic long_press,
    output logic repeat_pulse
);

    localparam int unsigned DW      = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
    localparam int unsigned MAX_LD  = (LONG_CYC > DBL_CYC) ? LONG_CYC : DBL_CYC;
    localparam int unsigned MAX_CYC = (MAX_LD > REP_CYC) ? MAX_LD : REP_CYC;
    localparam int unsigned TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS1    = 3'd1,
        LONG_HELD = 3'd2,
        WAIT2     = 3'd3,
        PRESS2    = 3'd4
    } state_t;

    logic          s0;
    logic          s1;
    logic [DW-1:0] deb_cnt;
    logic          deb_done_c;
    logic          rise_c;
    logic          fall_c;

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] timer;
    logic [TW-1:0] timer_nxt;
    logic          short_nxt;
    logic          double_nxt;
    logic          long_nxt;

    // Debounced level changes at the same edge the counter completes
    assign deb_done_c = (s1 != key_level) && (deb_cnt == DW'(DEB_CYC - 1));
    assign rise_c     = deb_done_c & s1;
    assign fall_c     = deb_done_c & ~s1;

    // Synchroniser and debounce counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s0        <= 1'b0;
            s1        <= 1'b0;
            deb_cnt   <= '0;
            key_level <= 1'b0;
            key_rise  <= 1'b0;
        end else begin
            s0       <= touch_raw;
            s1       <= s0;
            key_rise <= rise_c;
            if (s1 == key_level) begin
                deb_cnt <= '0;
            end else if (deb_done_c) begin
                deb_cnt   <= '0;
                key_level <= s1;
            end else begin
                deb_cnt <= deb_cnt + DW'(1);
            end
        end
    end

`ifdef TOUCH_REPEAT_EN
    logic rep_nxt;
`endif

    // Classifier next-state, shared timer and pulse decode
    always_comb begin
        state_nxt  = state;
        timer_nxt  = (timer == {TW{1'b1}}) ? timer : timer + TW'(1);
        short_nxt  = 1'b0;
        double_nxt = 1'b0;
        long_nxt   = 1'b0;
`ifdef TOUCH_REPEAT_EN
        rep_nxt    = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (rise_c) state_nxt = PRESS1;
            end
            PRESS1: begin
                if (fall_c) begin
                    state_nxt = WAIT2;
                end else if (timer == TW'(LONG_CYC - 1)) begin
                    long_nxt  = 1'b1;
                    state_nxt = LONG_HELD;
                end
            end
            LONG_HELD: begin
                if (fall_c) begin
                    state_nxt = IDLE;
`ifdef TOUCH_REPEAT_EN
                end else if (timer == TW'(REP_CYC - 1)) begin
                    rep_nxt   = 1'b1;
                    timer_nxt = '0;
`endif
                end
            end
            WAIT2: begin
                // A rise landing on the expiry cycle still counts as a double press
                if (rise_c) begin
                    double_nxt = 1'b1;
                    state_nxt  = PRESS2;
                end else if (timer == TW'(DBL_CYC - 1)) begin
                    short_nxt = 1'b1;
                    state_nxt = IDLE;
                end
            end
            PRESS2: begin
                if (fall_c) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (state_nxt != state) timer_nxt = '0;
    end

    // Classifier state, timer and registered pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            timer        <= '0;
            short_press  <= 1'b0;
            double_press <= 1'b0;
            long_press   <= 1'b0;
        end else begin
            state        <= state_nxt;
            timer        <= timer_nxt;
            short_press  <= short_nxt;
            double_press <= double_nxt;
            long_press   <= long_nxt;
        end
    end

`ifdef TOUCH_REPEAT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) repeat_pulse <= 1'b0;
        else        repeat_pulse <= rep_nxt;
    end
`else
    assign repeat_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_touch_key_cond.sv
// Directed bench for touch_key_cond with small timing parameters; pulse times are logged by cycle number.
module tb_touch_key_cond;

    logic clk = 1'b0;
    logic rst_n;
    logic touch_raw;
    logic key_level;
    logic key_rise;
    logic short_press;
    logic double_press;
    logic long_press;
    logic repeat_pulse;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int lvl_hi = 0;
    int excl_err = 0;
    int rise_q[$];
    int short_q[$];
    int dbl_q[$];
    int long_q[$];
    int rep_q[$];

    touch_key_cond #(
        .DEB_CYC (4),
        .LONG_CYC(20),
        .DBL_CYC (10),
        .REP_CYC (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .touch_raw   (touch_raw),
        .key_level   (key_level),
        .key_rise    (key_rise),
        .short_press (short_press),
        .double_press(double_press),
        .long_press  (long_press),
        .repeat_pulse(repeat_pulse)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Log every pulse with the cycle number it is observed in
    always @(negedge clk) begin
        if (key_rise)     rise_q.push_back(cyc);
        if (short_press)  short_q.push_back(cyc);
        if (double_press) dbl_q.push_back(cyc);
        if (long_press)   long_q.push_back(cyc);
        if (repeat_pulse) rep_q.push_back(cyc);
        if (key_level)    lvl_hi <= lvl_hi + 1;
        if (32'(short_press) + 32'(double_press) + 32'(long_press) + 32'(repeat_pulse) > 1 ||
            (key_rise && (short_press || long_press || repeat_pulse)))
            excl_err <= excl_err + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int n_in(input int q[$], input int lo, input int hi);
        int n = 0;
        foreach (q[i]) if (q[i] >= lo && q[i] < hi) n++;
        return n;
    endfunction

    function automatic int nth_in(input int q[$], input int lo, input int hi, input int k);
        int n = 0;
        foreach (q[i]) begin
            if (q[i] >= lo && q[i] < hi) begin
                if (n == k) return q[i];
                n++;
            end
        end
        return -1;
    endfunction

    task automatic hold(input logic v, input int n);
        touch_raw = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_level"}, 32'(key_level), 0);
        check({tag, "_rise"}, 32'(key_rise), 0);
        check({tag, "_short"}, 32'(short_press), 0);
        check({tag, "_double"}, 32'(double_press), 0);
        check({tag, "_long"}, 32'(long_press), 0);
        check({tag, "_repeat"}, 32'(repeat_pulse), 0);
    endtask

    initial begin
        int t0;
        int tr;
        int lv0;
        rst_n     = 1'b0;
        touch_raw = 1'b0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Bounce shorter than the debounce window
        t0  = cyc;
        lv0 = lvl_hi;
        for (int i = 0; i < 10; i++) hold(i % 2 == 0, 2);
        hold(1'b0, 30);
        check("bounce_level", lvl_hi - lv0, 0);
        check("bounce_rise", n_in(rise_q, t0, cyc + 1), 0);
        check("bounce_short", n_in(short_q, t0, cyc + 1), 0);
        check("bounce_long", n_in(long_q, t0, cyc + 1), 0);

        // Short press: 12 cycles held, fall debounced at +18, short at +28
        t0 = cyc;
        hold(1'b1, 12);
        hold(1'b0, 30);
        check("short_rise_n", n_in(rise_q, t0, cyc + 1), 1);
        check("short_rise_t", nth_in(rise_q, t0, cyc + 1, 0), t0 + 6);
        check("short_n", n_in(short_q, t0, cyc + 1), 1);
        check("short_t", nth_in(short_q, t0, cyc + 1, 0), t0 + 28);
        check("short_dbl", n_in(dbl_q, t0, cyc + 1), 0);
        check("short_long", n_in(long_q, t0, cyc + 1), 0);

        // Double press: 8 on, 6 off, 8 on; second rise at +20
        t0 = cyc;
        hold(1'b1, 8);
        hold(1'b0, 6);
        hold(1'b1, 8);
        hold(1'b0, 30);
        check("dbl_rise_n", n_in(rise_q, t0, cyc + 1), 2);
        check("dbl_rise2_t", nth_in(rise_q, t0, cyc + 1, 1), t0 + 20);
        check("dbl_n", n_in(dbl_q, t0, cyc + 1), 1);
        check("dbl_t", nth_in(dbl_q, t0, cyc + 1, 0), t0 + 20);
        check("dbl_short", n_in(short_q, t0, cyc + 1), 0);
        check("dbl_long", n_in(long_q, t0, cyc + 1), 0);

        // Long press: 40 cycles held, long at +26, fall at +46
        t0 = cyc;
        hold(1'b1, 40);
        hold(1'b0, 30);
        check("long_rise_t", nth_in(rise_q, t0, cyc + 1, 0), t0 + 6);
        check("long_n", n_in(long_q, t0, cyc + 1), 1);
        check("long_t", nth_in(long_q, t0, cyc + 1, 0), t0 + 26);
        check("long_short", n_in(short_q, t0, cyc + 1), 0);
        check("long_dbl", n_in(dbl_q, t0, cyc + 1), 0);
`ifdef TOUCH_REPEAT_EN
        check("long_rep_n", n_in(rep_q, t0, cyc + 1), 3);
        check("long_rep0_t", nth_in(rep_q, t0, cyc + 1, 0), t0 + 31);
        check("long_rep1_t", nth_in(rep_q, t0, cyc + 1, 1), t0 + 36);
        check("long_rep2_t", nth_in(rep_q, t0, cyc + 1, 2), t0 + 41);
`else
        check("long_rep_n", n_in(rep_q, t0, cyc + 1), 0);
`endif

        // Reset while in PRESS1 with the key still held
        t0 = cyc;
        hold(1'b1, 10);
        rst_n = 1'b0;
        @(negedge clk);
        check_outputs_zero("midrst");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tr = cyc;
        check("midrst_no_long", n_in(long_q, t0, tr + 1), 0);
        hold(1'b1, 30);
        hold(1'b0, 30);
        check("midrst_rise_t", nth_in(rise_q, tr, cyc + 1, 0), tr + 6);
        check("midrst_long_t", nth_in(long_q, tr, cyc + 1, 0), tr + 26);
        check("midrst_long_n", n_in(long_q, tr, cyc + 1), 1);

        // Race: second rise lands exactly on WAIT2 expiry (+24)
        t0 = cyc;
        hold(1'b1, 8);
        hold(1'b0, 10);
        hold(1'b1, 8);
        hold(1'b0, 30);
        check("race_dbl_t", nth_in(dbl_q, t0, cyc + 1, 0), t0 + 24);
        check("race_short", n_in(short_q, t0, cyc + 1), 0);

        // One cycle later: short fires first, second touch becomes a fresh press
        t0 = cyc;
        hold(1'b1, 8);
        hold(1'b0, 11);
        hold(1'b1, 8);
        hold(1'b0, 30);
        check("late_dbl", n_in(dbl_q, t0, cyc + 1), 0);
        check("late_short_n", n_in(short_q, t0, cyc + 1), 2);
        check("late_short0_t", nth_in(short_q, t0, cyc + 1, 0), t0 + 24);
        check("late_rise2_t", nth_in(rise_q, t0, cyc + 1, 1), t0 + 25);
        check("late_short1_t", nth_in(short_q, t0, cyc + 1, 1), t0 + 43);

        check("exclusive", excl_err, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
